// File: rtl/cache_bank_arbiter.sv
// cache_bank_arbiter: round-robin request arbiter with circular FIFO feeding 1-2 bank channels.
// Define CACHE_ARB_WRITE_ACK_EN to return write acknowledgements on resp_is_write.
module cache_bank_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int NUM_BANK_PORTS   = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_ADDR_WIDTH = 8,
  parameter int NET_ADDR_WIDTH   = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0]                   req_valid,
  output logic [NUM_PORTS-1:0]                   req_ready,
  input  logic [NUM_PORTS-1:0]                   req_write,
  input  logic [NUM_PORTS*CACHE_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*NET_ADDR_WIDTH-1:0]    req_src,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]        req_wdata,
  output logic [NUM_PORTS-1:0]                   resp_valid,
  output logic [NUM_PORTS-1:0]                   resp_is_write,
  output logic [NUM_PORTS*NET_ADDR_WIDTH-1:0]    resp_src,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]        resp_data,
  output logic [NUM_BANK_PORTS-1:0]              bank_en,
  output logic [NUM_BANK_PORTS-1:0]              bank_we,
  output logic [NUM_BANK_PORTS*CACHE_ADDR_WIDTH-1:0] bank_addr,
  output logic [NUM_BANK_PORTS*DATA_WIDTH-1:0]   bank_wdata,
  input  logic [NUM_BANK_PORTS*DATA_WIDTH-1:0]   bank_rdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count
);

  localparam int NP  = NUM_PORTS;
  localparam int NB  = NUM_BANK_PORTS;
  localparam int DW  = DATA_WIDTH;
  localparam int CAW = CACHE_ADDR_WIDTH;
  localparam int NW  = NET_ADDR_WIDTH;
  localparam int PW  = $clog2(NP);
  localparam int QW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);

  logic [PW-1:0]  q_port [FIFO_DEPTH];
  logic           q_we   [FIFO_DEPTH];
  logic [CAW-1:0] q_addr [FIFO_DEPTH];
  logic [NW-1:0]  q_src  [FIFO_DEPTH];
  logic [DW-1:0]  q_data [FIFO_DEPTH];

  logic [QW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rr_q, rr_d;

  logic [NP-1:0] rdy;
  logic [QW-1:0] slot [NP];
  logic [CW-1:0] n_acc;

  // Credit comes only from the registered count.
  always_comb begin
    int p;
    rdy   = '0;
    n_acc = '0;
    rr_d  = rr_q;
    p     = 0;
    for (int i = 0; i < NP; i++) slot[i] = '0;
    for (int k = 0; k < NP; k++) begin
      p = (int'(rr_q) + k) % NP;
      if (req_valid[p] &&
          int'(n_acc) < FIFO_DEPTH - int'(cnt_q)) begin
        rdy[p]  = 1'b1;
        slot[p] = tail_q + QW'(n_acc);
        n_acc   = n_acc + CW'(1);
        rr_d    = PW'((p + 1) % NP);
      end
    end
  end

  logic [QW-1:0] nxt;
  logic          pop0, pop1;
  logic [CW-1:0] n_pop;
  logic [NB-1:0] iss;

  assign nxt = head_q + QW'(1);

  always_comb begin
    pop0 = cnt_q != '0;
    pop1 = 1'b0;
    if (NB == 2 && cnt_q >= CW'(2))
      pop1 = (q_port[nxt] != q_port[head_q]) &&
             !((q_addr[nxt] == q_addr[head_q]) &&
               (q_we[nxt] || q_we[head_q]));
    iss    = '0;
    iss[0] = pop0;
    for (int c = 1; c < NB; c++) iss[c] = pop1;
    n_pop  = CW'(pop0) + CW'(pop1);
  end

  assign cnt_d = cnt_q + n_acc - n_pop;

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (rdy[p]) begin
        q_port[slot[p]] <= PW'(p);
        q_we[slot[p]]   <= req_write[p];
        q_addr[slot[p]] <= req_addr[p*CAW +: CAW];
        q_src[slot[p]]  <= req_src[p*NW +: NW];
        q_data[slot[p]] <= req_wdata[p*DW +: DW];
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
    end else begin
      head_q <= head_q + QW'(n_pop);
      tail_q <= tail_q + QW'(n_acc);
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  logic [NB-1:0]  en_q, we_q;
  logic [CAW-1:0] addr_q [NB];
  logic [DW-1:0]  wd_q   [NB];
  logic [PW-1:0]  ip_q   [NB];
  logic [NW-1:0]  is_q   [NB];

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= '0;
      we_q <= '0;
      for (int c = 0; c < NB; c++) begin
        addr_q[c] <= '0;
        wd_q[c]   <= '0;
        ip_q[c]   <= '0;
        is_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NB; c++) begin
        en_q[c] <= iss[c];
        we_q[c] <= iss[c] && q_we[head_q + QW'(c)];
        if (iss[c]) begin
          addr_q[c] <= q_addr[head_q + QW'(c)];
          wd_q[c]   <= q_data[head_q + QW'(c)];
          ip_q[c]   <= q_port[head_q + QW'(c)];
          is_q[c]   <= q_src[head_q + QW'(c)];
        end
      end
    end
  end

  assign bank_en = en_q;
  assign bank_we = we_q;

  always_comb begin
    bank_addr  = '0;
    bank_wdata = '0;
    for (int c = 0; c < NB; c++) begin
      bank_addr[c*CAW +: CAW] = addr_q[c];
      bank_wdata[c*DW +: DW]  = wd_q[c];
    end
  end

  logic [NB-1:0]    tv_q;
  logic [PW-1:0]    tp_q [NB];
  logic [NB-1:0]    rsp;
  logic [NB-1:0]    rd_tag;
  logic [NP*NW-1:0] rsrc_q;

`ifdef CACHE_ARB_WRITE_ACK_EN
  logic [NB-1:0] tw_q;
  assign rsp    = en_q;
  assign rd_tag = tv_q & ~tw_q;
`else
  assign rsp    = en_q & ~we_q;
  assign rd_tag = tv_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q   <= '0;
      rsrc_q <= '0;
      for (int c = 0; c < NB; c++) tp_q[c] <= '0;
`ifdef CACHE_ARB_WRITE_ACK_EN
      tw_q   <= '0;
`endif
    end else begin
      tv_q <= rsp;
`ifdef CACHE_ARB_WRITE_ACK_EN
      tw_q <= we_q;
`endif
      for (int c = 0; c < NB; c++) begin
        tp_q[c] <= ip_q[c];
        if (rsp[c])
          rsrc_q[int'(ip_q[c])*NW +: NW] <= is_q[c];
      end
    end
  end

  assign resp_src = rsrc_q;

  // Issue never pairs two entries of one port, so channels never collide here.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int c = 0; c < NB; c++) begin
      if (tv_q[c])
        resp_valid[tp_q[c]] = 1'b1;
      if (rd_tag[c])
        resp_data[int'(tp_q[c])*DW +: DW] = bank_rdata[c*DW +: DW];
    end
  end

`ifdef CACHE_ARB_WRITE_ACK_EN
  always_comb begin
    resp_is_write = '0;
    for (int c = 0; c < NB; c++)
      if (tv_q[c] && tw_q[c])
        resp_is_write[tp_q[c]] = 1'b1;
  end
`else
  assign resp_is_write = '0;
`endif

  assign req_ready  = rdy;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Directed bench for cache_bank_arbiter with a behavioural two-channel bank model.
// Expectations cover both CACHE_ARB_WRITE_ACK_EN builds.
module tb_cache_bank_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, req_write;
  logic [31:0]  req_addr;
  logic [15:0]  req_src;
  logic [127:0] req_wdata;
  logic [3:0]   resp_valid, resp_is_write;
  logic [15:0]  resp_src;
  logic [127:0] resp_data;
  logic [1:0]   bank_en, bank_we;
  logic [15:0]  bank_addr;
  logic [63:0]  bank_wdata, bank_rdata;
  logic [3:0]   fifo_count;

  int n_chk = 0;
  int n_err = 0;

  cache_bank_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_src(req_src), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_is_write(resp_is_write),
    .resp_src(resp_src), .resp_data(resp_data),
    .bank_en(bank_en), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Bank: mem[a] = A000_0000+a except 0x10; read data one cycle after bank_en.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
      mem[8'h10] = 32'hDEAD_BEEF;
      mem_init = 1'b1;
    end
    for (int c = 0; c < 2; c++)
      if (bank_en[c]) begin
        if (bank_we[c]) mem[bank_addr[c*8 +: 8]] = bank_wdata[c*32 +: 32];
        else bank_rdata[c*32 +: 32] <= mem[bank_addr[c*8 +: 8]];
      end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr();
    req_valid = '0;
  endtask

  task automatic put(input int p, input logic w, input logic [7:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    req_valid[p]         = 1'b1;
    req_write[p]         = w;
    req_addr[p*8 +: 8]   = a;
    req_src[p*4 +: 4]    = s;
    req_wdata[p*32 +: 32] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      clr();
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0;
    req_src = '0; req_wdata = '0;
    repeat (2) cyc();
    smp();
    chk("rst.cnt", fifo_count, 0);
    chk("rst.en", bank_en, 0);
    chk("rst.we", bank_we, 0);
    chk("rst.rv", resp_valid, 0);
    chk("rst.src", resp_src, 0);
    chk("rst.data", resp_data, 0);
    chk("rst.addr", bank_addr, 0);
    chk("rst.rdy", req_ready, 0);
    cyc(); reset = 1'b0;

    // single read from port 2
    cyc(); put(2, 0, 8'h10, 4'h5, 0); smp();
    chk("rd.rdy", req_ready, 4'b0100);
    cyc(); clr(); smp();
    chk("rd.cnt1", fifo_count, 1);
    chk("rd.en1", bank_en, 0);
    cyc(); smp();
    chk("rd.en2", bank_en, 2'b01);
    chk("rd.addr", bank_addr[7:0], 8'h10);
    chk("rd.cnt2", fifo_count, 0);
    cyc(); smp();
    chk("rd.rv", resp_valid, 4'b0100);
    chk("rd.src", resp_src[11:8], 4'h5);
    chk("rd.data", resp_data[95:64], 32'hDEAD_BEEF);
    cyc(); smp();
    chk("rd.rv4", resp_valid, 0);
    chk("rd.hold", resp_src[11:8], 4'h5);
    chk("rd.d4", resp_data, 0);

    // all four ports with rr_ptr at 0
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    cyc();
    for (int p = 0; p < 4; p++) put(p, 0, 8'(8'h40 + p), 4'(p + 8), 0);
    smp();
    chk("all.rdy", req_ready, 4'b1111);
    cyc(); clr(); smp();
    chk("all.cnt", fifo_count, 4);
    cyc(); smp();
    chk("all.en2", bank_en, 2'b11);
    chk("all.a2", bank_addr, 16'h4140);
    chk("all.cnt2", fifo_count, 2);
    cyc(); smp();
    chk("all.en3", bank_en, 2'b11);
    chk("all.a3", bank_addr, 16'h4342);
    chk("all.rv3", resp_valid, 4'b0011);
    chk("all.d0", resp_data[31:0], 32'hA000_0040);
    chk("all.d1", resp_data[63:32], 32'hA000_0041);
    chk("all.cnt3", fifo_count, 0);
    cyc(); smp();
    chk("all.rv4", resp_valid, 4'b1100);
    chk("all.d3", resp_data[127:96], 32'hA000_0043);
    chk("all.s3", resp_src[15:12], 4'hB);

    // fill with same-address writes: single pops, rotating grants
    begin
      logic [3:0] rdy_exp [6];
      logic [3:0] cnt_exp [6];
      rdy_exp = '{4'b1111, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      cnt_exp = '{4'd0, 4'd4, 4'd7, 4'd7, 4'd7, 4'd7};
      idle(2);
      for (int k = 0; k < 6; k++) begin
        cyc();
        for (int p = 0; p < 4; p++)
          put(p, 1, 8'h60, 4'(p), 32'hC0DE_0000 + p);
        smp();
        chk($sformatf("fill.rdy%0d", k), req_ready, rdy_exp[k]);
        chk($sformatf("fill.cnt%0d", k), fifo_count, cnt_exp[k]);
        if (k == 2) chk("fill.en2", bank_en, 2'b01);
      end
      cyc(); clr(); smp();
      for (int i = 0; i < 20 && fifo_count != 0; i++) begin
        cyc(); smp();
      end
      chk("fill.drain", fifo_count, 0);
      idle(3);
    end

    // write then read of 0x20 from different ports
    cyc();
    put(0, 1, 8'h20, 4'h1, 32'h1234_5678);
    put(1, 0, 8'h20, 4'h7, 0);
    smp();
    chk("hz.rdy", req_ready, 4'b0011);
    cyc(); clr(); smp();
    chk("hz.cnt1", fifo_count, 2);
    cyc(); smp();
    chk("hz.en2", bank_en, 2'b01);
    chk("hz.we2", bank_we, 2'b01);
    chk("hz.cnt2", fifo_count, 1);
    cyc(); smp();
    chk("hz.en3", bank_en, 2'b01);
    chk("hz.we3", bank_we, 2'b00);
`ifdef CACHE_ARB_WRITE_ACK_EN
    chk("hz.ack", resp_valid, 4'b0001);
    chk("hz.isw", resp_is_write, 4'b0001);
`else
    chk("hz.noack", resp_valid, 4'b0000);
`endif
    cyc(); smp();
    chk("hz.rv", resp_valid, 4'b0010);
    chk("hz.data", resp_data[63:32], 32'h1234_5678);
    chk("hz.src", resp_src[7:4], 4'h7);
    idle(3);

    // two adjacent reads from port 1 behind a write chain
    cyc();
    put(2, 1, 8'h38, 4'h2, 32'hAAAA_0002);
    put(3, 1, 8'h38, 4'h3, 32'hAAAA_0003);
    put(0, 1, 8'h38, 4'h0, 32'hAAAA_0000);
    smp();
    chk("sp.rdy0", req_ready, 4'b1101);
    cyc(); clr(); put(1, 0, 8'h38, 4'h1, 0); smp();
    chk("sp.cnt1", fifo_count, 3);
    chk("sp.rdy1", req_ready, 4'b0010);
    cyc(); clr(); put(1, 0, 8'h32, 4'h1, 0); smp();
    chk("sp.rdy2", req_ready, 4'b0010);
    cyc(); clr();
    cyc(); smp();
    chk("sp.cnt4", fifo_count, 2);
    cyc(); smp();
    chk("sp.en5", bank_en, 2'b01);
    chk("sp.a5", bank_addr[7:0], 8'h38);
    chk("sp.cnt5", fifo_count, 1);
    cyc(); smp();
    chk("sp.en6", bank_en, 2'b01);
    chk("sp.a6", bank_addr[7:0], 8'h32);
    chk("sp.rv6", resp_valid, 4'b0010);
    chk("sp.d6", resp_data[63:32], 32'hAAAA_0000);
    cyc(); smp();
    chk("sp.rv7", resp_valid, 4'b0010);
    chk("sp.d7", resp_data[63:32], 32'hA000_0032);
    idle(3);

    // reset while reads are in flight
    cyc();
    put(2, 0, 8'h10, 4'h2, 0);
    put(3, 0, 8'h11, 4'h3, 0);
    put(0, 0, 8'h12, 4'h4, 0);
    cyc(); clr();
    cyc(); reset = 1'b1; smp();
    chk("mr.en", bank_en, 2'b11);
    cyc(); reset = 1'b0; smp();
    chk("mr.rv", resp_valid, 0);
    chk("mr.cnt", fifo_count, 0);
    chk("mr.en0", bank_en, 0);
    chk("mr.src", resp_src, 0);
    chk("mr.isw", resp_is_write, 0);

    // write from port 3 after reset
    cyc(); put(3, 1, 8'h44, 4'hA, 32'h55); smp();
    chk("wr.rdy", req_ready, 4'b1000);
    cyc(); clr();
    cyc(); smp();
    chk("wr.en", bank_en, 2'b01);
    chk("wr.we", bank_we, 2'b01);
    chk("wr.addr", bank_addr[7:0], 8'h44);
    cyc(); smp();
`ifdef CACHE_ARB_WRITE_ACK_EN
    chk("wr.rv", resp_valid, 4'b1000);
    chk("wr.isw", resp_is_write, 4'b1000);
    chk("wr.src", resp_src[15:12], 4'hA);
    chk("wr.data", resp_data[127:96], 0);
`else
    chk("wr.rv", resp_valid, 4'b0000);
    chk("wr.isw", resp_is_write, 4'b0000);
`endif
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
